// File: rtl/kitten_axil_pkg.sv
// Shared AXI-Lite definitions for the kitten tile: response codes, register map
// and the master FSM state encoding.
package kitten_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] ADDR_CONTROL = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_ALPHA   = 8'h08;
    localparam logic [7:0] ADDR_V_TH    = 8'h0C;
    localparam logic [7:0] ADDR_SCALE_Q = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } axil_state_t;

endpackage

// File: rtl/kitten_axil_if.sv
// AXI-Lite bus bundle; master drives address/data/valids, slave drives readys
// and responses.
interface kitten_axil_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/kitten_axil_master.sv
// Single-outstanding AXI-Lite master: command/response front end with a
// bus-phase timeout that aborts a stalled transaction with SLVERR.
module kitten_axil_master
    import kitten_axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    kitten_axil_if.master           m_axil
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    axil_state_t             state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    awvalid_q, wvalid_q;
    logic [15:0]             to_cnt;

    logic cmd_fire, aw_fire, w_fire, aw_done, w_done, bus_phase, to_hit;
    logic arvalid_c, bready_c, rready_c, rsp_valid_c;

    assign cmd_ready = (state == IDLE) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign aw_fire   = awvalid_q && m_axil.awready;
    assign w_fire    = wvalid_q && m_axil.wready;
    assign aw_done   = !awvalid_q || aw_fire;
    assign w_done    = !wvalid_q || w_fire;
    assign bus_phase = state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
    // The limit bounds the whole transaction, so a later phase entered past it
    // only survives if its own handshake is already there.
    assign to_hit    = bus_phase && (to_cnt >= TO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        arvalid_c   = 1'b0;
        bready_c    = 1'b0;
        rready_c    = 1'b0;
        rsp_valid_c = 1'b0;
        case (state)
            IDLE:    if (cmd_fire) state_n = cmd_write ? WR : RD_ADDR;
            WR: begin
                if (aw_done && w_done) state_n = WR_RESP;
                else if (to_hit)       state_n = RSP;
            end
            WR_RESP: begin
                bready_c = 1'b1;
                if (m_axil.bvalid || to_hit) state_n = RSP;
            end
            RD_ADDR: begin
                arvalid_c = 1'b1;
                if (m_axil.arready) state_n = RD_DATA;
                else if (to_hit)    state_n = RSP;
            end
            RD_DATA: begin
                rready_c = 1'b1;
                if (m_axil.rvalid || to_hit) state_n = RSP;
            end
            RSP: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            to_cnt      <= '0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q      <= cmd_addr;
                wdata_q     <= cmd_wdata;
                wstrb_q     <= cmd_wstrb;
                awvalid_q   <= cmd_write;
                wvalid_q    <= cmd_write;
                to_cnt      <= '0;
                rsp_timeout <= 1'b0;
            end else begin
                if (bus_phase)                   to_cnt    <= to_cnt + 16'd1;
                if (aw_fire || state_n != WR)    awvalid_q <= 1'b0;
                if (w_fire || state_n != WR)     wvalid_q  <= 1'b0;
            end

            if (state == WR_RESP && m_axil.bvalid) begin
                rsp_resp  <= m_axil.bresp;
                rsp_rdata <= '0;
            end else if (state == RD_DATA && m_axil.rvalid) begin
                rsp_resp  <= m_axil.rresp;
                rsp_rdata <= m_axil.rdata;
            end else if (to_hit && state_n == RSP) begin
                rsp_resp    <= RESP_SLVERR;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign m_axil.awaddr  = addr_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.arvalid = arvalid_c;
    assign m_axil.bready  = bready_c;
    assign m_axil.rready  = rready_c;
    assign rsp_valid      = rsp_valid_c;

endmodule
